wm_cfg_i2c_responder: RTL
=========================

Name: wm_cfg_i2c_responder

Overview:
- Synthesizable I2C target (write-only) modelling the codec control port that our configuration sequencer drives.
- Accepts 24-bit frames {device address byte, 16-bit control word}, where the control word is {7-bit reg addr, 9-bit data}, and updates a codec-style register file.
- Exposes the register contents to on-board logic and the bench, for loopback checking of the config ROM sequence (power, master, sound select, volumes, active).

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; the write address byte is 8'h34.
- NUM_REGS, 10, number of implemented registers (0..9). Reg 15 is the reset command and is not stored.
- FILT_LEN, 3, stable-sample count for the glitch filter (used only with the optional feature).

Ports:
- CLOCK  in  1  system clock; oversamples SCL/SDA. Minimum 8x the SCL rate.
- RESET  in  1  synchronous, active-high reset.
- I2C_SCLK  in  1  bus SCL (asynchronous).
- I2C_SDAT_IN  in  1  bus SDA as sampled (asynchronous).
- I2C_SDAT_OE  out  1  1 = pull SDA low (ACK); 0 = release.
- WR_STB  out  1  one-cycle pulse on each committed register write.
- WR_ADDR  out  7  register address of the last commit.
- WR_DATA  out  9  data of the last commit.
- RD_ADDR  in  4  combinational readback index.
- RD_DATA  out  9  register[RD_ADDR]; 0 if RD_ADDR >= NUM_REGS.
- HP_VOL_L  out  7  reg2[6:0].
- HP_VOL_R  out  7  reg3[6:0].
- ACTIVE  out  1  reg9[0].
- NACK_CNT  out  8  saturating count of NACKed bytes.

Behaviour:
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized values.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Reset values:
  - I2C_SDAT_OE=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, NACK_CNT=0.
  - Registers take codec defaults: R0=0x097, R1=0x097, R2=0x079, R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=0x000, R9=0x000.
  - FSM returns to IDLE.
- FSM states: IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE.
  - Data bits shift MSB first on the SCL rising edge.
  - The bit counter wraps 7→0 after each byte.
  - IDLE→ADDR on START.
  - After the 8th address bit:
    - If the byte is {DEV_ADDR,0}, go to ACK_A.
    - Otherwise (address mismatch or R/W=1), do not drive SDA, increment NACK_CNT, and go to IGNORE.
  - ACK states:
    - On the first SCL falling edge after the 8th bit, set I2C_SDAT_OE=1.
    - On the next SCL falling edge, set I2C_SDAT_OE=0 and advance to the next state.
    - Sequence: ACK_A→HI, ACK_H→LO, ACK_L→IGNORE.
  - Commit timing: commit occurs in the CLOCK cycle after the 8th LO bit is sampled. WR_STB pulses that cycle and WR_ADDR/WR_DATA update.
  - Commit effect:
    - Address < NUM_REGS: register written.
    - Address 15 with any data: all registers return to defaults.
    - Any other address: ACKed, WR_STB pulses, no storage.
  - Bytes after the 3rd in the same frame are NACKed. Each increments NACK_CNT, saturating at 255.
  - STOP in any state→IDLE, with I2C_SDAT_OE=0 in the same cycle. A partial frame is discarded without commit.
  - Repeated START in any state→ADDR, bit counter cleared, partial frame discarded.
  - RESET mid-frame releases SDA immediately and discards the frame.
- Simultaneous events: when RESET is asserted, it takes priority over START/STOP detection in that cycle.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: each synchronized line feeds a filter that updates its output only after FILT_LEN consecutive equal samples. This adds FILT_LEN cycles of latency to all edges and commits.
- Undefined: lines are used directly after the 2-flop synchronizer; FILT_LEN is ignored.

Decomposition:
- Package wm_cfg_pkg:
  - Register index constants: REG_LHP=2, REG_RHP=3, REG_ACTIVE=9, REG_RESET=15.
  - Default-value array.
  - FSM state enum.
  - Address-byte constant 8'h34.
- One sub-module, i2c_line_cond: synchronizer, optional filter, rise/fall detect. Instantiated once each for SCL and SDA.

Test Plan:
- Frame 0x34,0x04,0x60 (reg2=0x060) → three ACKs; WR_STB once with WR_ADDR=2, WR_DATA=0x060; HP_VOL_L=0x60; RD_ADDR=2 gives 0x060.
- Frame 0x34,0x12,0x01 → reg9=0x001, ACTIVE=1. Then frame 0x34,0x1E,0x00 → all registers at defaults, ACTIVE=0, HP_VOL_R=0x79.
- Frame 0x36,... → no ACK on any byte, I2C_SDAT_OE never 1, no WR_STB, NACK_CNT=1.
- Frame 0x34,0x06,0x70,0xAA → reg3=0x070 committed; 4th byte NACKed; NACK_CNT=1.
- Frame 0x34,0x04 then repeated START, then 0x34,0x06,0x65 → only reg3=0x065 written; reg2 stays 0x079.
- RESET pulsed during the ACK_H low phase → I2C_SDAT_OE=0 next cycle; no WR_STB; all registers at defaults.

Source files
------------

// File: rtl/wm_cfg_pkg.sv
// Shared constants for the codec-style configuration responder: register
// indices, power-on register defaults, FSM state encoding and bus address byte.
package wm_cfg_pkg;

  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_ACTIVE = 7'd9;
  localparam logic [6:0] REG_RESET  = 7'd15;

  localparam logic [7:0] ADDR_BYTE_WR = 8'h34;

  // Indices beyond the implemented register count read as zero.
  localparam logic [8:0] REG_DEFAULTS [16] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
  };

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous I2C line: 2-flop synchronizer, optional glitch
// filter (enabled by I2C_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic line_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1;
  logic level_q, prev_q;

  // Idle bus level is high, so flops reset to 1 to avoid a false edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= line_async;
      sync_p1 <= sync_p0;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Output follows only after FILT_LEN consecutive differing samples.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else if (sync_p1 == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
      level_q <= sync_p1;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_filt;
  assign unused_filt = ^FILT_LEN;
  assign level_q     = sync_p1;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) prev_q <= 1'b1;
    else       prev_q <= level_q;
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/wm_cfg_i2c_responder.sv
// Write-only I2C target modelling the codec control port; 24-bit frames update
// a codec-style register file. Optional input glitch filter: I2C_GLITCH_FILTER_EN.
module wm_cfg_i2c_responder
  import wm_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = ADDR_BYTE_WR[7:1],
  parameter int unsigned NUM_REGS = 10,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  output logic       WR_STB,
  output logic [6:0] WR_ADDR,
  output logic [8:0] WR_DATA,
  input  logic [3:0] RD_ADDR,
  output logic [8:0] RD_DATA,
  output logic [6:0] HP_VOL_L,
  output logic [6:0] HP_VOL_R,
  output logic       ACTIVE,
  output logic [7:0] NACK_CNT
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_scl_cond (
    .CLOCK(CLOCK), .RESET(RESET), .line_async(I2C_SCLK),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_sda_cond (
    .CLOCK(CLOCK), .RESET(RESET), .line_async(I2C_SDAT_IN),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  i2c_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic        ack_on_q;
  logic        count_extra_q;
  logic        commit_q;
  logic [7:0]  shift_q;
  logic [7:0]  hi_q;
  logic [8:0]  regs [NUM_REGS];
  logic [7:0]  byte_next;

  assign byte_next = {shift_q[6:0], sda};

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      ack_on_q      <= 1'b0;
      count_extra_q <= 1'b0;
      commit_q      <= 1'b0;
      I2C_SDAT_OE   <= 1'b0;
      WR_STB        <= 1'b0;
      WR_ADDR       <= 7'd0;
      WR_DATA       <= 9'd0;
      NACK_CNT      <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_DEFAULTS[i];
    end else begin
      WR_STB   <= 1'b0;
      commit_q <= 1'b0;

      // Commit stage: one cycle after the last data bit was sampled.
      if (commit_q) begin
        WR_STB  <= 1'b1;
        WR_ADDR <= hi_q[7:1];
        WR_DATA <= {hi_q[0], shift_q};
        if (hi_q[7:1] == REG_RESET) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_DEFAULTS[i];
        end else begin
          for (int i = 0; i < NUM_REGS; i++)
            if (hi_q[7:1] == 7'(i)) regs[i] <= {hi_q[0], shift_q};
        end
      end

      if (stop_det) begin
        state_q     <= IDLE;
        I2C_SDAT_OE <= 1'b0;
        ack_on_q    <= 1'b0;
      end else if (start_det) begin
        state_q       <= ADDR;
        bit_cnt_q     <= 3'd0;
        I2C_SDAT_OE   <= 1'b0;
        ack_on_q      <= 1'b0;
        count_extra_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR, HI, LO: begin
            if (scl_rise) begin
              shift_q   <= byte_next;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ADDR) begin
                  if (byte_next == {DEV_ADDR, 1'b0}) begin
                    state_q <= ACK_A;
                  end else begin
                    NACK_CNT      <= sat_inc(NACK_CNT);
                    count_extra_q <= 1'b0;
                    state_q       <= IGNORE;
                  end
                end else if (state_q == HI) begin
                  hi_q    <= byte_next;
                  state_q <= ACK_H;
                end else begin
                  commit_q <= 1'b1;
                  state_q  <= ACK_L;
                end
              end
            end
          end
          ACK_A, ACK_H, ACK_L: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                I2C_SDAT_OE <= 1'b1;
                ack_on_q    <= 1'b1;
              end else begin
                I2C_SDAT_OE <= 1'b0;
                ack_on_q    <= 1'b0;
                bit_cnt_q   <= 3'd0;
                if (state_q == ACK_A)      state_q <= HI;
                else if (state_q == ACK_H) state_q <= LO;
                else begin
                  state_q       <= IGNORE;
                  count_extra_q <= 1'b1;
                end
              end
            end
          end
          IGNORE: begin
            // ack_on_q marks the 9th (ACK) clock of an extra byte, which is skipped.
            if (scl_rise && count_extra_q) begin
              if (ack_on_q) begin
                ack_on_q <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  NACK_CNT <= sat_inc(NACK_CNT);
                  ack_on_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    RD_DATA = 9'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (RD_ADDR == 4'(i)) RD_DATA = regs[i];
  end

  assign HP_VOL_L = regs[REG_LHP][6:0];
  assign HP_VOL_R = regs[REG_RHP][6:0];
  assign ACTIVE   = regs[REG_ACTIVE][0];

endmodule
